// File: rtl/seg7_pkg.sv
// Shared types and the active-high segment pattern table for the 7-segment scan decoder.
// Segment order is g..a, i.e. bit0 = a through bit6 = g.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  localparam seg7_t SEG7_PATTERNS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_pattern_to_nibble.sv
// Combinational reverse lookup: active-high segment pattern to hex nibble.
// hit is low for any pattern outside the 16-entry table (including all-off).
import seg7_pkg::*;

module seg7_pattern_to_nibble (
  input  seg7_t      seg,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!hit && seg == SEG7_PATTERNS[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus.
// Define SEG7_SCAN_DP_EN to add the decimal-point input seg_dp_n and per-digit dp output.
import seg7_pkg::*;

module seg7_scan_decoder #(
  parameter  int DIGITS        = 4,
  parameter  int STABLE_CYCLES = 4,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_n,
`ifdef SEG7_SCAN_DP_EN
  input  logic                  seg_dp_n,
  output logic [DIGITS-1:0]     dp,
`endif
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_done
);

`ifdef SEG7_SCAN_DP_EN
  localparam int DP_W = 1;
`else
  localparam int DP_W = 0;
`endif
  localparam int SW = SEG_W + DIGITS + DP_W;

  logic [SW-1:0]        samp_in, sync1_q, sync2_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 captured_q, captured_d;
  logic [DIGITS-1:0]    mask_q, mask_d;
  logic [4*DIGITS-1:0]  value_q, value_d;
  logic [DIGITS-1:0]    valid_q, valid_d, err_q, err_d;
  logic                 fd_q, fd_d;
  logic [DIGITS-1:0]    cur_dig;
  seg7_t                cur_seg;
  logic [3:0]           dec_nib;
  logic                 dec_hit, same, one_hot, stable_hit, capture;

  // Sync flops hold active-high copies so their reset value means "bus idle".
`ifdef SEG7_SCAN_DP_EN
  logic [DIGITS-1:0]    dp_q, dp_d;
  assign samp_in = {~seg_dp_n, ~seg_n, ~dig_n};
`else
  assign samp_in = {~seg_n, ~dig_n};
`endif

  assign cur_dig = sync2_q[DIGITS-1:0];
  assign cur_seg = sync2_q[DIGITS +: SEG_W];

  seg7_pattern_to_nibble u_lookup (
    .seg    (cur_seg),
    .nibble (dec_nib),
    .hit    (dec_hit)
  );

  always_comb begin
    // Comparing the two sync stages looks one sample ahead, keeping latency at STABLE_CYCLES+2.
    same       = (sync1_q == sync2_q);
    one_hot    = (cur_dig != '0) && ((cur_dig & (cur_dig - 1'b1)) == '0);
    stable_hit = same && (cnt_q == CNT_W'(STABLE_CYCLES - 1)) && !captured_q;
    capture    = stable_hit && one_hot;

    cnt_d      = '0;
    captured_d = 1'b0;
    if (same) begin
      cnt_d      = (cnt_q == CNT_W'(STABLE_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
      captured_d = captured_q | stable_hit;
    end

    value_d = value_q;
    valid_d = valid_q;
    err_d   = err_q;
`ifdef SEG7_SCAN_DP_EN
    dp_d    = dp_q;
`endif
    fd_d    = (mask_q == '1);
    mask_d  = fd_d ? '0 : mask_q;

    if (capture) begin
      mask_d = mask_d | cur_dig;
      for (int i = 0; i < DIGITS; i++) begin
        if (cur_dig[i]) begin
          if (dec_hit) value_d[4*i +: 4] = dec_nib;
          valid_d[i] = dec_hit;
          err_d[i]   = !dec_hit;
`ifdef SEG7_SCAN_DP_EN
          dp_d[i]    = sync2_q[SW-1];
`endif
        end
      end
    end

    if (clear) begin
      value_d = '0;
      valid_d = '0;
      err_d   = '0;
      mask_d  = '0;
      fd_d    = 1'b0;
`ifdef SEG7_SCAN_DP_EN
      dp_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= '0;
      captured_q <= 1'b0;
      mask_q     <= '0;
      value_q    <= '0;
      valid_q    <= '0;
      err_q      <= '0;
      fd_q       <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
      dp_q       <= '0;
`endif
    end else begin
      sync1_q    <= samp_in;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      fd_q       <= fd_d;
`ifdef SEG7_SCAN_DP_EN
      dp_q       <= dp_d;
`endif
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign frame_done  = fd_q;
`ifdef SEG7_SCAN_DP_EN
  assign dp          = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with a sample-history reference model
// checked every cycle, plus literal expectations at key points.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int SC     = 4;
  localparam int PW     = 8 + DIGITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic [6:0] seg_n = '1;
  logic [DIGITS-1:0] dig_n = '1;
  logic seg_dp_n = 1'b1;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0] digit_valid, digit_err;
  logic frame_done;
`ifdef SEG7_SCAN_DP_EN
  logic [DIGITS-1:0] dp;
`endif

  always #5 clk = ~clk;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
`ifdef SEG7_SCAN_DP_EN
    .seg_dp_n    (seg_dp_n),
    .dp          (dp),
`endif
    .clear       (clear),
    .value       (value),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .frame_done  (frame_done)
  );

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_checks = 0;
  int n_fail   = 0;
  int fd_count = 0;

  // Model: raw pin samples at past edges, newest first.
  logic [PW-1:0]       hist [SC+2];
  logic [4*DIGITS-1:0] m_value;
  logic [DIGITS-1:0]   m_valid, m_err, m_mask, m_dp;
  logic                m_fd;

  function automatic logic [PW-1:0] pins_now();
`ifdef SEG7_SCAN_DP_EN
    return {seg_dp_n, seg_n, dig_n};
`else
    return {1'b1, seg_n, dig_n};
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic                cap;
    logic [DIGITS-1:0]   adig;
    logic [6:0]          aseg;
    logic [4*DIGITS-1:0] nv;
    logic [DIGITS-1:0]   nvalid, nerr, nmask, ndp;
    logic                nfd, found;
    int                  nib;
    if (!rst_n) begin
      for (int k = 0; k < SC + 2; k++) hist[k] <= '1;
      m_value <= '0; m_valid <= '0; m_err <= '0; m_mask <= '0; m_dp <= '0; m_fd <= 1'b0;
    end else begin
      // A capture needs SC+1 identical pin samples preceded by a different one.
      cap = 1'b1;
      for (int k = 0; k < SC; k++) if (hist[k] != hist[k+1]) cap = 1'b0;
      if (hist[SC+1] == hist[SC]) cap = 1'b0;
      adig = ~hist[0][DIGITS-1:0];
      aseg = ~hist[0][DIGITS +: 7];
      if ($countones(adig) != 1) cap = 1'b0;
      nv = m_value; nvalid = m_valid; nerr = m_err; ndp = m_dp;
      nfd = (m_mask == '1);
      nmask = nfd ? '0 : m_mask;
      if (cap) begin
        found = 1'b0; nib = 0;
        for (int h = 0; h < 16; h++) if (!found && HEX[h] == aseg) begin found = 1'b1; nib = h; end
        for (int d = 0; d < DIGITS; d++) if (adig[d]) begin
          if (found) nv[4*d +: 4] = 4'(nib);
          nvalid[d] = found;
          nerr[d]   = !found;
          ndp[d]    = ~hist[0][PW-1];
          nmask[d]  = 1'b1;
        end
      end
      if (clear) begin
        nv = '0; nvalid = '0; nerr = '0; nmask = '0; ndp = '0; nfd = 1'b0;
      end
      m_value <= nv; m_valid <= nvalid; m_err <= nerr; m_mask <= nmask; m_dp <= ndp; m_fd <= nfd;
      for (int k = SC + 1; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= pins_now();
    end
  end

  always @(negedge clk) begin : compare
    logic [PW+4*DIGITS+1:0] act, exp;
    if (rst_n) begin
`ifdef SEG7_SCAN_DP_EN
      act = {value, digit_valid, digit_err, frame_done, dp};
`else
      act = {value, digit_valid, digit_err, frame_done, m_dp};
`endif
      exp = {m_value, m_valid, m_err, m_fd, m_dp};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t: dut {value,valid,err,fd,dp}=%h model=%h", $time, act, exp);
      end
      if (frame_done) fd_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s = %h", name, act);
  endtask

  // Called just after a rising edge (+2); returns in the same phase.
  task automatic scan_digit(input int d, input logic [6:0] pat, input int hold, input logic dpv);
    dig_n    = ~(DIGITS'(1) << d);
    seg_n    = ~pat;
    seg_dp_n = ~dpv;
    repeat (hold) @(posedge clk);
    #2;
    dig_n = '1; seg_n = '1; seg_dp_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic scan_1a3f();
    scan_digit(0, HEX[15], 10, 1'b0);
    scan_digit(1, HEX[3],  10, 1'b1);
    scan_digit(2, HEX[10], 10, 1'b0);
    scan_digit(3, HEX[1],  10, 1'b0);
  endtask

  initial begin
    int fd_base;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_value", 32'(value), 32'h0);
    check("idle_valid", 32'(digit_valid), 32'h0);
    check("idle_err", 32'(digit_err), 32'h0);
    check("idle_frames", 32'(fd_count), 32'd0);
    @(posedge clk); #2;

    fd_base = fd_count;
    scan_1a3f();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scan_value", 32'(value), 32'h1A3F);
    check("scan_valid", 32'(digit_valid), 32'hF);
    check("scan_err", 32'(digit_err), 32'h0);
    check("scan_frames", 32'(fd_count - fd_base), 32'd1);
`ifdef SEG7_SCAN_DP_EN
    check("scan_dp", 32'(dp), 32'h2);
`endif
    @(posedge clk); #2;

    scan_digit(2, 7'h49, 10, 1'b0);
    @(negedge clk);
    check("nonhex_value", 32'(value), 32'h1A3F);
    check("nonhex_valid", 32'(digit_valid), 32'hB);
    check("nonhex_err", 32'(digit_err), 32'h4);
    @(posedge clk); #2;

    scan_digit(2, HEX[5], SC - 1, 1'b0);
    dig_n = 4'b1100; seg_n = ~HEX[8];
    repeat (10) @(posedge clk);
    #2 dig_n = '1; seg_n = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("short_twohot_value", 32'(value), 32'h1A3F);
    check("short_twohot_valid", 32'(digit_valid), 32'hB);
    @(posedge clk); #2;

    // Clear lands on the very edge that would capture digit 0 = "7".
    dig_n = ~4'b0001; seg_n = ~HEX[7];
    repeat (5) @(posedge clk);
    #2 clear = 1'b1;
    @(posedge clk);
    #2 clear = 1'b0;
    @(negedge clk);
    check("clear_value", 32'(value), 32'h0);
    check("clear_valid", 32'(digit_valid), 32'h0);
    check("clear_err", 32'(digit_err), 32'h0);
    check("clear_fd", 32'(frame_done), 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("clear_no_recapture", 32'(digit_valid), 32'h0);
    @(posedge clk); #2;
    dig_n = '1; seg_n = '1;
    repeat (2) @(posedge clk); #2;
    fd_base = fd_count;
    scan_1a3f();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rescan_value", 32'(value), 32'h1A3F);
    check("rescan_valid", 32'(digit_valid), 32'hF);
    check("rescan_frames", 32'(fd_count - fd_base), 32'd1);
    @(posedge clk); #2;

    dig_n = ~4'b0010; seg_n = ~HEX[5]; seg_dp_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_err_fd", 32'({digit_err, frame_done}), 32'h0);
`ifdef SEG7_SCAN_DP_EN
    check("rst_dp", 32'(dp), 32'h0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_rst_wait", 32'(digit_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_valid", 32'(digit_valid), 32'h2);
    check("post_rst_value", 32'(value), 32'h0050);
`ifdef SEG7_SCAN_DP_EN
    check("post_rst_dp", 32'(dp), 32'h2);
`endif
    @(posedge clk); #2;
    dig_n = '1; seg_n = '1; seg_dp_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Recovers hex digits from a time-multiplexed, active-low 7-segment display bus: segment lines plus per-digit strobes.
- Inverse of the nibble-to-segment path. Used for on-board loopback self-test of the CISC front panel and as a bench monitor.
- Synchronises the pins, waits for a stable digit slot, maps the segment pattern back to a nibble, and assembles a DIGITS-wide value with per-digit valid/error flags.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before capture (>=2).
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seg_n  in  7  segment lines, active-low; bit0=a … bit6=g.
- dig_n  in  DIGITS  digit strobes, active-low; bit i = digit i (digit 0 = least significant nibble).
- clear  in  1  synchronous clear of captured state.
- value  out  4*DIGITS  captured nibbles; value[4i+3:4i] = digit i.
- digit_valid  out  DIGITS  digit i holds a decoded nibble.
- digit_err  out  DIGITS  last capture of digit i was a non-hex pattern.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the previous pulse or clear.

Behaviour:
- Reset (rst_n low, asynchronous): value=0, digit_valid=0, digit_err=0, frame_done=0. Sync flops, counter, captured flag and frame mask are all 0.
- Input sync: seg_n and dig_n each pass through 2 flop stages. The synchronised sample S is {~seg_n, ~dig_n}, i.e. internally active-high.
- Stability counter:
  - If S is unchanged from the previous cycle, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the counter is cleared to 0 and the captured flag is cleared.
- Capture condition: counter == STABLE_CYCLES-1, S unchanged this cycle, and captured flag = 0. The captured flag is then set, giving exactly one capture per stable period.
- Digit select: the digit bits of S must be one-hot. With zero or multiple digits active, nothing is captured (blanking or ghosting interval); the counter still runs.
- Latency: outputs update STABLE_CYCLES+2 clock edges after a clean pin change.
- Pattern match, active-high segments g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71
- On capture of digit i:
  - Hit: value nibble i = decoded nibble, digit_valid[i]=1, digit_err[i]=0.
  - Miss (any other pattern, including all-off): nibble i unchanged, digit_valid[i]=0, digit_err[i]=1.
  - In both cases frame mask bit i is set.
- frame_done:
  - When the mask becomes all-ones, frame_done pulses on the next cycle and the mask clears that same cycle.
  - If a capture coincides with that clear, the capture's mask bit survives.
- clear: same effect as reset on value, valid, err and mask. The sync/stability pipeline is not reset. clear has priority over a same-cycle capture; that capture is dropped. frame_done is forced 0 in that cycle.
- Reset asserted mid-operation: immediate return to reset values. The first capture after release needs a full STABLE_CYCLES period.

Optional Feature:
- Macro SEG7_SCAN_DP_EN.
- Defined:
  - Adds input seg_dp_n (1, active-low decimal point), synchronised and included in the stability comparison alongside S.
  - Adds output dp (DIGITS). dp[i] is captured on every digit-i capture regardless of hit/miss, and reset/cleared to 0.
  - The decimal point is excluded from pattern matching.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package seg7_pkg:
  - SEG7_PATTERNS constant array (16 x 7 bits, active-high, g..a).
  - Segment bit-index constants.
  - Typedef seg7_t (logic [6:0]).
- Sub-module seg7_pattern_to_nibble: combinational; input seg7_t; outputs nibble[3:0] and hit. This is the only lookup instance.
- Sync, stability, capture and frame logic stay in the top module.

Test Plan:
- Reset then idle (dig_n all 1): value=0, valid=0, err=0, no frame_done ever.
- Scan "1A3F" with DIGITS=4, 10 cycles per digit plus 2-cycle blanking between digits: value=16'h1A3F, valid=4'hF, err=0, frame_done pulses once per full scan.
- Digit 2 driven with seg_n=~7'h49 (non-hex): digit_err[2]=1, valid[2]=0, nibble 2 retains its prior value; other digits unaffected.
- Digit strobe held for only STABLE_CYCLES-1 cycles, and a two-hot dig_n=4'b1100: no capture, value unchanged.
- clear asserted on the same cycle as a capture of digit 0 = "7": value=0, valid=0, mask empty, frame_done=0. Re-scan recovers normally.
- rst_n pulsed low mid-digit: outputs 0 immediately. With SEG7_SCAN_DP_EN, dp tracks seg_dp_n per digit and resets to 0.
